div_unit: RTL

Iterative signed 32-bit divider for the datapath's HI/LO register pair, the companion of the Booth multiplier. On a start pulse it takes dividend and divisor and runs one restoring-division step per clock. It writes the quotient to Lo and the remainder to Hi, matching MIPS DIV semantics, and flags divide-by-zero.

---
 rtl/div_pkg.sv | 25 ++
 rtl/div_step.sv | 36 +++
 rtl/div_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// ============================================================================
// div_pkg : shared types and constants for the iterative signed divider
// Revision: 1.0
// ============================================================================
`default_nettype none

package div_pkg;

  localparam int DIV_WIDTH = 32;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ITER   = 2'd1,
    FINISH = 2'd2
  } div_state_e;

endpackage : div_pkg

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// div_step : one combinational restoring-division step on {rem, quo}
// Revision: 1.0
// ============================================================================
`default_nettype none

module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The shifted remainder needs WIDTH+1 bits; the restored value is always
  // below the divisor, so it fits back into WIDTH bits.
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    trial   = shifted - {1'b0, divisor_i};
    if (!trial[WIDTH]) begin
      rem_o = trial[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule : div_step

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
// div_unit : iterative signed divider, quotient to Lo, remainder to Hi
// Revision: 1.0
// ============================================================================
`default_nettype none

module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] DivA,
  input  logic [WIDTH-1:0] DivB,
  input  logic             DivControl,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  localparam int CNT_W = cnt_width(WIDTH);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             signq_q, signq_d;
  logic             signr_q, signr_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             divzero_q, divzero_d;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] step_rem, step_quo;

  // Magnitudes as unsigned WIDTH-bit values; the most negative input maps to itself.
  assign abs_a = DivA[WIDTH-1] ? (~DivA + 1'b1) : DivA;
  assign abs_b = DivB[WIDTH-1] ? (~DivB + 1'b1) : DivB;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvsr_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      signq_q   <= 1'b0;
      signr_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      signq_q   <= signq_d;
      signr_q   <= signr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    signq_d   = signq_q;
    signr_d   = signr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    divzero_d = divzero_q;

    case (state_q)
      IDLE: begin
        if (DivControl) begin
          if (DivB == '0) begin
            divzero_d = 1'b1;
            state_d   = FINISH;
          end else begin
            divzero_d = 1'b0;
            quo_d     = abs_a;
            dvsr_d    = abs_b;
            rem_d     = '0;
            signq_d   = DivA[WIDTH-1] ^ DivB[WIDTH-1];
            signr_d   = DivA[WIDTH-1];
            cnt_d     = CNT_W'(WIDTH - 1);
            state_d   = ITER;
          end
        end
      end

      ITER: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = FINISH;
        end
      end

      FINISH: begin
        if (!divzero_q) begin
          lo_d = signq_q ? (~quo_q + 1'b1) : quo_q;
          hi_d = signr_q ? (~rem_q + 1'b1) : rem_q;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Hi      = hi_q;
  assign Lo      = lo_q;
  assign Busy    = (state_q != IDLE);
  assign Done    = done_q;
  assign DivZero = divzero_q;

endmodule : div_unit

`default_nettype wire
